// File: rtl/seg_scanner_if.sv
// -----------------------------------------------------------------------------
// seg_scanner_if
// Bundles the data/handshake side of the 7-segment scanner.
//   seg_in      : concatenated digit patterns, digit i at [8i+7:8i]
//   update_rdy  : single-cycle strobe, capture seg_in
//   blink_en    : level, blank segments during blink-off phase
//   seg_out     : shared segment bus (bit 7 = a ... bit 0 = dp)
//   dig_sel     : one-hot digit enable
//   frame_done  : one-cycle pulse on the last cycle of the last digit slot
// master = the block feeding patterns and reading the display lines,
// slave  = the scanner itself.
// -----------------------------------------------------------------------------
interface seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [8*NUM_DIGITS-1:0] seg_in;
    logic                    update_rdy;
    logic                    blink_en;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    frame_done;

    modport master (
        output seg_in, update_rdy, blink_en,
        input  seg_out, dig_sel, frame_done
    );

    modport slave (
        input  seg_in, update_rdy, blink_en,
        output seg_out, dig_sel, frame_done
    );
endinterface

// File: rtl/seg_scanner.sv
// -----------------------------------------------------------------------------
// seg_scanner
// Time-multiplexed 7-segment driver. Scans NUM_DIGITS digits over one shared
// segment bus, blanks the last DEAD_CYCLES of every slot against ghosting,
// blinks the whole display on request and double-buffers the patterns so the
// displayed frame only changes on a frame boundary.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : seg_scanner_if.slave (seg_in, update_rdy, blink_en in;
//            seg_out, dig_sel, frame_done out, all registered)
// -----------------------------------------------------------------------------
module seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 10,
    parameter int DEAD_CYCLES = 1,
    parameter int BLINK_DIV   = 5000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scanner_if.slave  bus
);

    // Counter widths hold the terminal value itself so SHOW_LEN compares cleanly.
    localparam int CNT_W    = $clog2(SCAN_DIV + 1);
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W    = $clog2(BLINK_DIV + 1);
    localparam int SHOW_LEN = SCAN_DIV - DEAD_CYCLES;

    localparam logic                  POL     = (ACTIVE_LOW != 0);
    localparam logic [7:0]            OFF_SEG = {8{POL}};
    localparam logic [NUM_DIGITS-1:0] OFF_SEL = {NUM_DIGITS{POL}};

    typedef enum logic {
        SLOT_SHOW = 1'b0,
        SLOT_DEAD = 1'b1
    } slot_e;

    slot_e                       state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [BLK_W-1:0]            blk_q, blk_d;
    logic                        blink_off_q, blink_off_d;
    logic [NUM_DIGITS-1:0][7:0]  shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][7:0]  active_q, active_d;

    logic                        slot_end;
    logic                        frame_end;
    logic                        blink_wrap;
    logic [7:0]                  seg_d;
    logic [NUM_DIGITS-1:0]       sel_d;

    assign slot_end   = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign frame_end  = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign blink_wrap = (blk_q == BLK_W'(BLINK_DIV - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would chain updates within one edge.
    // NOTE: the pattern buffers are reset (not left as uninitialised storage)
    // because a released reset must show a blank display, never stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SLOT_SHOW;
            cnt_q       <= '0;
            idx_q       <= '0;
            blk_q       <= '0;
            blink_off_q <= 1'b0;
            shadow_q    <= '0;
            active_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            blk_q       <= blk_d;
            blink_off_q <= blink_off_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state: slot/digit counters, blink timebase, double buffer
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        blk_d       = blink_wrap ? '0 : blk_q + 1'b1;
        blink_off_d = blink_off_q ^ blink_wrap;
        shadow_d    = shadow_q;
        active_d    = active_q;

        if (slot_end) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // Slot phase follows the counter value it will hold after this edge.
        state_d = (cnt_d < CNT_W'(SHOW_LEN)) ? SLOT_SHOW : SLOT_DEAD;

        if (bus.update_rdy) begin
            shadow_d = bus.seg_in;
        end
        // shadow_d already includes a coincident strobe, so a strobe on the
        // boundary cycle goes straight into the active buffer.
        if (frame_end) begin
            active_d = shadow_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode of the current state (active-high internally)
    // -------------------------------------------------------------------------
    always_comb begin
        seg_d = '0;
        sel_d = '0;
        if (state_q == SLOT_SHOW) begin
            sel_d = NUM_DIGITS'(1) << idx_q;
            if (!(bus.blink_en && blink_off_q)) begin
                seg_d = active_q[idx_q];
            end
        end
    end

    // Output registers: polarity is applied only here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.seg_out    <= OFF_SEG;
            bus.dig_sel    <= OFF_SEL;
            bus.frame_done <= 1'b0;
        end else begin
            bus.seg_out    <= seg_d ^ OFF_SEG;
            bus.dig_sel    <= sel_d ^ OFF_SEL;
            bus.frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_scanner
// Drives an active-high and an active-low scanner with identical stimulus and
// compares both against a reference model computed from cycle arithmetic:
// slot position, frame number, the strobe history and the blink window.
// -----------------------------------------------------------------------------
module tb_seg_scanner;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BD = 64;
    localparam int FR = ND * SD;

    typedef struct {
        int          t;
        logic [31:0] v;
    } strobe_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg_scanner_if #(.NUM_DIGITS(ND)) bus_h ();
    seg_scanner_if #(.NUM_DIGITS(ND)) bus_l ();

    seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC),
                  .BLINK_DIV(BD), .ACTIVE_LOW(0))
        dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h));

    seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC),
                  .BLINK_DIV(BD), .ACTIVE_LOW(1))
        dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;   // state cycle since reset release
    strobe_t     hist[$];
    logic [7:0]  e_seg;
    logic [ND-1:0] e_sel;
    logic        e_fd;

    // Drive one cycle of stimulus, compute the expected registered output of
    // the coming edge, then advance to 1 time unit after that edge.
    task automatic tick(input logic [31:0] d, input logic s, input logic b);
        int          cn, ix, fr;
        logic [31:0] act;
        @(negedge clk);
        bus_h.seg_in = d; bus_h.update_rdy = s; bus_h.blink_en = b;
        bus_l.seg_in = d; bus_l.update_rdy = s; bus_l.blink_en = b;
        if (s) hist.push_back('{cyc, d});
        cn  = cyc % SD;
        ix  = (cyc / SD) % ND;
        fr  = cyc / FR;
        // Active data of frame fr = last strobe before that frame started.
        act = '0;
        foreach (hist[i]) if (hist[i].t < fr * FR) act = hist[i].v;
        e_fd = (cn == SD - 1) && (ix == ND - 1);
        if (cn < SD - DC) begin
            e_sel = ND'(1) << ix;
            e_seg = (b && ((cyc / BD) % 2 == 1)) ? 8'h00 : act[8*ix +: 8];
        end else begin
            e_sel = '0;
            e_seg = 8'h00;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus_h.seg_out !== 8'h00 || bus_h.dig_sel !== 4'b0000 || bus_h.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_high: seg=%h sel=%b fd=%b, required seg=00 sel=0000 fd=0",
                     bus_h.seg_out, bus_h.dig_sel, bus_h.frame_done);
        end
        n_checks++;
        if (bus_l.seg_out !== 8'hFF || bus_l.dig_sel !== 4'b1111 || bus_l.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_low: seg=%h sel=%b fd=%b, required seg=ff sel=1111 fd=0",
                     bus_l.seg_out, bus_l.dig_sel, bus_l.frame_done);
        end
        // Release just after an edge so the next edge is edge 1.
        #1 rst_n = 1'b1;
        cyc = 0;
        hist.delete();
    endtask

    task automatic test_basic_scan();
        int pulses = 0;
        for (int i = 0; i < 3 * FR; i++) begin
            tick(32'h1234_5678, i == 0, 1'b0);
            if (bus_h.frame_done === 1'b1) pulses++;
            n_checks++;
            if (bus_h.seg_out !== e_seg || bus_h.dig_sel !== e_sel || bus_h.frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL basic_high cyc=%0d: seg=%h sel=%b fd=%b, required seg=%h sel=%b fd=%b",
                         cyc, bus_h.seg_out, bus_h.dig_sel, bus_h.frame_done, e_seg, e_sel, e_fd);
            end
            n_checks++;
            if (bus_l.seg_out !== ~e_seg || bus_l.dig_sel !== ~e_sel || bus_l.frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL basic_low cyc=%0d: seg=%h sel=%b fd=%b, required seg=%h sel=%b fd=%b",
                         cyc, bus_l.seg_out, bus_l.dig_sel, bus_l.frame_done, ~e_seg, ~e_sel, e_fd);
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL frame_done_count: saw %0d pulses, required 3", pulses);
        end
    endtask

    task automatic test_update_timing();
        // Mid-frame strobe at slot 1 of a frame, boundary strobe, then a
        // double strobe inside one frame.
        for (int i = 0; i < 6 * FR; i++) begin
            logic [31:0] d;
            logic        s;
            d = 32'h0;
            s = 1'b0;
            if (i == 12)              begin d = 32'hAAAA_AAAA; s = 1'b1; end
            if (i == 2 * FR + FR - 1) begin d = 32'hC3A5_5A3C; s = 1'b1; end
            if (i == 4 * FR + 5)      begin d = 32'h1111_1111; s = 1'b1; end
            if (i == 4 * FR + 20)     begin d = 32'h9E8D_7C6B; s = 1'b1; end
            tick(d, s, 1'b0);
            n_checks++;
            if (bus_h.seg_out !== e_seg || bus_h.dig_sel !== e_sel || bus_h.frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL update_high cyc=%0d: seg=%h sel=%b fd=%b, required seg=%h sel=%b fd=%b",
                         cyc, bus_h.seg_out, bus_h.dig_sel, bus_h.frame_done, e_seg, e_sel, e_fd);
            end
            n_checks++;
            if (bus_l.seg_out !== ~e_seg || bus_l.dig_sel !== ~e_sel || bus_l.frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL update_low cyc=%0d: seg=%h sel=%b fd=%b, required seg=%h sel=%b fd=%b",
                         cyc, bus_l.seg_out, bus_l.dig_sel, bus_l.frame_done, ~e_seg, ~e_sel, e_fd);
            end
        end
    endtask

    task automatic test_blink();
        for (int i = 0; i < 256 + 40; i++) begin
            tick(32'h0, 1'b0, i < 256);
            n_checks++;
            if (bus_h.seg_out !== e_seg || bus_h.dig_sel !== e_sel || bus_h.frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL blink_high cyc=%0d: seg=%h sel=%b fd=%b, required seg=%h sel=%b fd=%b",
                         cyc, bus_h.seg_out, bus_h.dig_sel, bus_h.frame_done, e_seg, e_sel, e_fd);
            end
            n_checks++;
            if (bus_l.seg_out !== ~e_seg || bus_l.dig_sel !== ~e_sel || bus_l.frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL blink_low cyc=%0d: seg=%h sel=%b fd=%b, required seg=%h sel=%b fd=%b",
                         cyc, bus_l.seg_out, bus_l.dig_sel, bus_l.frame_done, ~e_seg, ~e_sel, e_fd);
            end
        end
    endtask

    task automatic test_async_reset();
        // Advance to mid-slot of digit 2, then pulse reset between edges.
        while ((cyc % FR) != 2 * SD + 3) tick(32'h0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_h.seg_out !== 8'h00 || bus_h.dig_sel !== 4'b0000 || bus_h.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_high: seg=%h sel=%b fd=%b, required seg=00 sel=0000 fd=0",
                     bus_h.seg_out, bus_h.dig_sel, bus_h.frame_done);
        end
        n_checks++;
        if (bus_l.seg_out !== 8'hFF || bus_l.dig_sel !== 4'b1111 || bus_l.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_low: seg=%h sel=%b fd=%b, required seg=ff sel=1111 fd=0",
                     bus_l.seg_out, bus_l.dig_sel, bus_l.frame_done);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc = 0;
        hist.delete();
        // Blank until a fresh strobe crosses a frame boundary.
        for (int i = 0; i < 3 * FR; i++) begin
            tick(32'hFEDC_BA98, i == FR + 7, 1'b0);
            n_checks++;
            if (bus_h.seg_out !== e_seg || bus_h.dig_sel !== e_sel || bus_h.frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL post_reset_high cyc=%0d: seg=%h sel=%b fd=%b, required seg=%h sel=%b fd=%b",
                         cyc, bus_h.seg_out, bus_h.dig_sel, bus_h.frame_done, e_seg, e_sel, e_fd);
            end
            n_checks++;
            if (bus_l.seg_out !== ~e_seg || bus_l.dig_sel !== ~e_sel || bus_l.frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL post_reset_low cyc=%0d: seg=%h sel=%b fd=%b, required seg=%h sel=%b fd=%b",
                         cyc, bus_l.seg_out, bus_l.dig_sel, bus_l.frame_done, ~e_seg, ~e_sel, e_fd);
            end
        end
    endtask

    task automatic test_random();
        logic b = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) b = ~b;
            tick($urandom, $urandom_range(0, 15) == 0, b);
            n_checks++;
            if (bus_h.seg_out !== e_seg || bus_h.dig_sel !== e_sel || bus_h.frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL random_high cyc=%0d: seg=%h sel=%b fd=%b, required seg=%h sel=%b fd=%b",
                         cyc, bus_h.seg_out, bus_h.dig_sel, bus_h.frame_done, e_seg, e_sel, e_fd);
            end
            n_checks++;
            if (bus_l.seg_out !== ~e_seg || bus_l.dig_sel !== ~e_sel || bus_l.frame_done !== e_fd) begin
                n_fail++;
                $display("FAIL random_low cyc=%0d: seg=%h sel=%b fd=%b, required seg=%h sel=%b fd=%b",
                         cyc, bus_l.seg_out, bus_l.dig_sel, bus_l.frame_done, ~e_seg, ~e_sel, e_fd);
            end
        end
    endtask

    initial begin
        bus_h.seg_in = '0; bus_h.update_rdy = 1'b0; bus_h.blink_en = 1'b0;
        bus_l.seg_in = '0; bus_l.update_rdy = 1'b0; bus_l.blink_en = 1'b0;
        test_reset();
        test_basic_scan();
        test_update_timing();
        test_blink();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scanner.md
# seg_scanner

Time-multiplexed 7-segment driver for the ramen timer display. Sits directly downstream of the per-digit decoder chain: takes the concatenated 8-bit segment patterns of all digits and drives one shared segment bus plus a one-hot digit select. Adds inter-digit ghost-blanking, whole-display blink and frame-aligned double buffering so a carry ripple never tears a displayed frame.

## Interface
- NUM_DIGITS, 4, digits scanned; ≥ 1
- SCAN_DIV, 10, clk cycles per digit slot; ≥ 2
- DEAD_CYCLES, 1, blanked cycles at the end of each slot; 0 ≤ DEAD_CYCLES < SCAN_DIV
- BLINK_DIV, 5000, clk cycles per blink half-period; ≥ 1
- ACTIVE_LOW, 0, 1 inverts seg_out and dig_sel at the output registers

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- seg_in  in  8*NUM_DIGITS  digit i pattern at [8i+7:8i]; bit 7 = segment a … bit 0 = dp
- update_rdy  in  1  single-cycle strobe: capture seg_in
- blink_en  in  1  level: blank all segments during blink-off phase
- seg_out  out  8  shared segment bus (registered)
- dig_sel  out  NUM_DIGITS  one-hot digit enable; all inactive during dead time (registered)
- frame_done  out  1  one-cycle pulse on the last cycle of the last digit slot (registered)

## Operation
- State: slot counter `cnt` (0..SCAN_DIV-1), digit index `idx` (0..NUM_DIGITS-1), shadow buffer, active buffer, blink counter, blink phase.
- Two-state slot FSM per digit: SHOW while cnt < SCAN_DIV-DEAD_CYCLES, DEAD otherwise. cnt increments every cycle; at SCAN_DIV-1 it wraps to 0 and idx advances, wrapping NUM_DIGITS-1 → 0.
- SHOW decode: dig_sel bit idx active, seg_out = active[idx], or all segments off if blink_en=1 and blink phase = off.
- DEAD decode: dig_sel all inactive, seg_out all off.
- Frame boundary = cnt = SCAN_DIV-1 and idx = NUM_DIGITS-1.
- update_rdy=1 loads seg_in into shadow. Active loads from shadow only at a frame boundary. If update_rdy coincides with a frame boundary, seg_in loads directly into active (and shadow). Multiple strobes within one frame: last one wins.
- Blink counter free-runs 0..BLINK_DIV-1; phase toggles at each wrap, independent of blink_en. blink_en only masks segments; scanning never stops.
- "Off"/"inactive" means 0 when ACTIVE_LOW=0 and 1 when ACTIVE_LOW=1. All internal logic is active-high; inversion is applied at the output registers only.

## Timing
- Reset (rst_n=0, asynchronous): cnt=0, idx=0, shadow=0, active=0, blink counter=0, phase=on. seg_out=off, dig_sel all inactive, frame_done=0.
- Outputs are registered decodes of the current state. Edge 1 after reset release presents digit 0 SHOW (cnt=0 decode).
- Per slot: dig_sel is active for SCAN_DIV-DEAD_CYCLES cycles, then inactive for DEAD_CYCLES cycles. Frame period = NUM_DIGITS*SCAN_DIV cycles.
- frame_done is high for exactly the output cycle carrying the frame-boundary decode.
- New data latency: strobe → visible from the first slot of the next frame, i.e. the edge after the boundary decode.
- blink_en change affects the next output cycle.
- Reset asserted mid-frame clears outputs immediately. Scanning restarts at digit 0 with active=0.
- DEAD_CYCLES=0: no blank gap; dig_sel goes directly from one digit to the next.

## Test plan
Config for all scenarios: NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2, BLINK_DIV=64, ACTIVE_LOW=0.
- Reset release, seg_in=0x12345678, strobe on cycle 0 → frame 1 blank. Frame 2: dig_sel 0001 with seg_out 0x78 for 6 cycles, 0000 for 2 cycles, then 0010/0x56, 0100/0x34, 1000/0x12. frame_done pulses every 32 cycles.
- Strobe seg_in=0xAAAAAAAA mid-frame while displaying 0x12345678 → remaining digits of the current frame still show old values; next frame shows 0xAA on all digits.
- Strobe exactly on the frame-boundary cycle → new value visible from the immediately following slot. Two strobes in one frame → only the second value appears.
- blink_en=1 held for 256 cycles → seg_out=0x00 for alternating 64-cycle windows while dig_sel keeps scanning. Deassert → segments reappear on the next output cycle.
- ACTIVE_LOW=1 rerun of scenario 1 → seg_out/dig_sel bitwise inverted; reset and dead time drive 0xFF/1111.
- rst_n pulsed low mid-slot on digit 2 → outputs go inactive asynchronously. After release, digit 0 is shown with seg_out=0x00 until the next strobe plus frame boundary.
